ws2812_apb_chain: RTL and testbench
===================================

# ws2812_apb_chain

APB3 slave that stores a parametrised number of 24-bit GRB pixel words and serialises them onto one WS2812-style single-wire LED chain. Software writes pixels, then triggers a frame or enables continuous refresh. Timing is set by parameters. Status, a frame-done pulse and error reporting are provided. It sits on the fabric APB3 bus beside the other memory-mapped peripherals.

## Interface
- NUM_LEDS, 24: pixels in chain; legal range 1..1022.
- BIT_CYCLES, 125: PCLK cycles per data bit.
- T0H_CYCLES, 40: high cycles for a 0 bit; must satisfy 0 < T0H < T1H.
- T1H_CYCLES, 80: high cycles for a 1 bit; must satisfy T1H < BIT_CYCLES.
- RESET_CYCLES, 6000: low latch interval after the last bit.
- PCLK  in  1  clock; all logic is on its rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
- PADDR  in  32  byte address; only PADDR[11:2] is decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  constant 1; zero wait states.
- PSLVERR  out  1  error signal.
- LED  out  1  serial data to the chain; registered.
- FRAME_DONE  out  1  one-cycle pulse at the end of each frame's latch interval.

## Operation
- Register map by word index w = PADDR[11:2]:
  - w < NUM_LEDS: PIXEL[w], bits [23:0]. Reads return [31:24] as 0.
  - w = 0x3FE: CTRL.
    - bit0 START: write-1 pulse; reads as 0.
    - bit1 AUTO: read/write.
  - w = 0x3FF: STATUS.
    - bit0 BUSY: read-only.
    - bit1 DONE: sticky; cleared by writing 1 to it.
  - Any other w is unmapped. PSLVERR=1 during its access phase; writes are ignored and reads return 0.
- Access phase is PSEL & PENABLE. Writes commit on that edge. PRDATA is driven combinationally from PADDR during the access phase and is 0 otherwise.
- FSM states: IDLE, SEND, LATCH.
  - IDLE → SEND: a START write. pixel=0, bit=23, cyc=0, and the shifter loads PIXEL[0].
  - SEND:
    - LED=1 while cyc < THIGH; LED=0 otherwise.
    - THIGH = T1H_CYCLES if the current shifter bit is 1, else T0H_CYCLES.
    - cyc wraps at BIT_CYCLES-1, then bit decrements.
    - After bit 0, pixel increments and the shifter reloads PIXEL[pixel]. Bits go out MSB first: [23:16]=G, [15:8]=R, [7:0]=B.
    - After bit 0 of pixel NUM_LEDS-1 → LATCH.
  - LATCH: LED=0 for RESET_CYCLES cycles. Then DONE is set and FRAME_DONE pulses. Next state is SEND with pixel 0 if AUTO=1, else IDLE.
- BUSY=1 in SEND and LATCH.
- START while BUSY is ignored.
- Clearing AUTO mid-frame lets the current frame complete, then the block goes to IDLE.
- A pixel write during a frame takes effect only if that pixel has not yet been loaded into the shifter.
- Write to a pixel on the same edge as its load: the shifter takes the old value and the buffer takes the new one.
- DONE set and a DONE clear-write on the same edge: set wins.
- Counter widths come from $clog2 of their parameter maxima; there is no overflow beyond the wrap points.

## Timing
- Reset values: LED=0, FRAME_DONE=0, PRDATA=0, PSLVERR=0, all PIXEL=0, CTRL=0, STATUS=0, state IDLE.
- Assertion of PRESET mid-frame forces LED low asynchronously and aborts the frame; no resume occurs.
- START committed at edge T: LED rises at edge T+1.
- Each bit: exactly THIGH cycles high, then BIT_CYCLES-THIGH cycles low. There is no gap between bits or between pixels.
- Frame length: NUM_LEDS×24×BIT_CYCLES cycles of SEND plus RESET_CYCLES cycles of LATCH.
- FRAME_DONE and DONE assert on the same edge that leaves LATCH.
- In AUTO mode, the next frame's first high begins on the edge after the FRAME_DONE edge… more precisely, on the cycle after FRAME_DONE is high.

## Test plan
Bench parameters: NUM_LEDS=2, BIT_CYCLES=10, T0H=3, T1H=7, RESET_CYCLES=20.
- Reset defaults: hold PRESET, then release.
  - Required: LED=0, all reads return 0, BUSY=0.
  - Assert PRESET mid-SEND: LED drops immediately.
- Single frame: write PIXEL0=0xFF0000 and PIXEL1=0x000001, then START.
  - Required: 8 pulses of 7-high/3-low, then 39 pulses of 3/7, then 1 pulse of 7/3.
  - Required: 20 low cycles, then FRAME_DONE for 1 cycle, DONE=1, BUSY=0.
  - Total frame is 500 cycles.
- Register edges:
  - Read PIXEL0 after writing 0xABCDEF12: returns 0x00CDEF12.
  - Access w=2: PSLVERR=1 and no state change.
  - Write 1 to STATUS.DONE: DONE clears.
- START while BUSY: issue at cycle 100 of a frame.
  - Required: frame length unchanged; no second frame starts.
- AUTO refresh: set AUTO, then START.
  - Required: back-to-back 500-cycle frames with FRAME_DONE every 500 cycles.
  - Clear AUTO mid-frame: exactly one more FRAME_DONE, then IDLE.
- Mid-frame update: during pixel 0, write PIXEL1=0x800000.
  - Required: pixel 1's first bit is 7-high.
  - Same write during pixel 1: no change until the next frame.

Source files
------------

// File: rtl/ws2812_apb_chain.sv
// APB3 slave holding a GRB pixel buffer and driving a WS2812 LED chain.
// One frame = every pixel MSB-first, then a low latch interval.
module ws2812_apb_chain #(
  parameter int NUM_LEDS     = 24,
  parameter int BIT_CYCLES   = 125,
  parameter int T0H_CYCLES   = 40,
  parameter int T1H_CYCLES   = 80,
  parameter int RESET_CYCLES = 6000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        LED,
  output logic        FRAME_DONE
);

  localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [PW-1:0] PMAX = PW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] CMAX = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H  = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H  = CW'(T1H_CYCLES);
  localparam logic [LW-1:0] LMAX = LW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic [4:0]    bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [23:0]   shift_q, shift_d;
  logic          auto_q, auto_d;
  logic          done_q, done_d;
  logic          led_q, led_d;
  logic          fd_q, fd_d;
  logic [23:0]   pix_q [NUM_LEDS];

  logic [9:0]    w;
  logic [PW-1:0] pix_w;
  logic [PW-1:0] pix_nxt;
  logic [CW-1:0] thigh;
  logic          acc, wr, busy;
  logic          hit_pix, hit_ctrl, hit_stat;
  logic          start_wr;
  logic          unused_ok;

  assign w        = PADDR[11:2];
  assign pix_w    = w[PW-1:0];
  assign acc      = PSEL & PENABLE;
  assign wr       = acc & PWRITE;
  assign hit_pix  = w < 10'(NUM_LEDS);
  assign hit_ctrl = w == 10'h3FE;
  assign hit_stat = w == 10'h3FF;
  assign start_wr = wr & hit_ctrl & PWDATA[0];
  assign busy     = state_q != IDLE;
  assign pix_nxt  = pixel_q + PW'(1);
  assign thigh    = shift_q[23] ? T1H : T0H;

  assign PREADY     = 1'b1;
  assign PSLVERR    = acc & ~(hit_pix | hit_ctrl | hit_stat);
  assign LED        = led_q;
  assign FRAME_DONE = fd_q;
  assign unused_ok  = ^{PADDR[31:12], PADDR[1:0], PWDATA[31:24]};

  always_comb begin
    PRDATA = '0;
    if (acc) begin
      unique case (1'b1)
        hit_pix:  PRDATA = {8'h00, pix_q[pix_w]};
        hit_ctrl: PRDATA = {30'h0, auto_q, 1'b0};
        hit_stat: PRDATA = {30'h0, done_q, busy};
        default:  PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_LEDS; i++) pix_q[i] <= '0;
    end else if (wr && hit_pix) begin
      pix_q[pix_w] <= PWDATA[23:0];
    end
  end

  always_comb begin
    state_d = state_q;
    pixel_d = pixel_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    lat_d   = lat_q;
    shift_d = shift_q;
    led_d   = 1'b0;
    fd_d    = 1'b0;
    auto_d  = auto_q;
    done_d  = done_q;
    if (wr && hit_ctrl) auto_d = PWDATA[1];
    if (wr && hit_stat && PWDATA[1]) done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_d = SEND;
          pixel_d = '0;
          bit_d   = 5'd23;
          cyc_d   = '0;
          shift_d = pix_q[0];
        end
      end
      SEND: begin
        led_d = cyc_q < thigh;
        if (cyc_q == CMAX) begin
          cyc_d = '0;
          if (bit_q == 5'd0) begin
            bit_d = 5'd23;
            if (pixel_q == PMAX) begin
              state_d = LATCH;
              lat_d   = '0;
            end else begin
              pixel_d = pix_nxt;
              shift_d = pix_q[pix_nxt];
            end
          end else begin
            bit_d   = bit_q - 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      LATCH: begin
        if (lat_q == LMAX) begin
          fd_d   = 1'b1;
          done_d = 1'b1;
          if (auto_q) begin
            state_d = SEND;
            pixel_d = '0;
            bit_d   = 5'd23;
            cyc_d   = '0;
            shift_d = pix_q[0];
          end else begin
            state_d = IDLE;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      pixel_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      lat_q   <= '0;
      shift_q <= '0;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pixel_q <= pixel_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      lat_q   <= lat_d;
      shift_q <= shift_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
      led_q   <= led_d;
      fd_q    <= fd_d;
    end
  end

endmodule

// File: tb/tb_ws2812_apb_chain.sv
// Directed bench for ws2812_apb_chain: register table plus
// cycle-exact LED waveform checks against a pixel-level model.
module tb_ws2812_apb_chain;

  logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, LED, FRAME_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_led [2000];
  logic cap_fd  [2000];

  localparam logic [31:0] A_P0   = 32'h000;
  localparam logic [31:0] A_P1   = 32'h004;
  localparam logic [31:0] A_CTRL = 32'hFF8;
  localparam logic [31:0] A_STAT = 32'hFFC;

  ws2812_apb_chain #(
    .NUM_LEDS(2), .BIT_CYCLES(10), .T0H_CYCLES(3),
    .T1H_CYCLES(7), .RESET_CYCLES(20)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .LED(LED), .FRAME_DONE(FRAME_DONE)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic apb(input logic [31:0] a, input logic [31:0] d,
                     input logic w, output logic [31:0] rd,
                     output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w;
    PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rd = PRDATA; err = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic err;
    apb(a, d, 1'b1, rd, err);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] rd; logic err;
    apb(a, 32'h0, 1'b0, rd, err);
    chk(nm, rd, exp);
  endtask

  task automatic capture(input int len);
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        @(posedge PCLK);
        #1;
      end
      cap_led[i] = LED;
      cap_fd[i]  = FRAME_DONE;
    end
  endtask

  // LED level j cycles after the START edge of one frame
  function automatic logic pat(input int j, input logic [23:0] p0,
                               input logic [23:0] p1);
    int q, bp, c;
    logic [23:0] px;
    logic b;
    if (j < 1 || j > 480) return 1'b0;
    q  = j - 1;
    bp = q / 10;
    c  = q % 10;
    px = (bp < 24) ? p0 : p1;
    b  = px[23 - (bp % 24)];
    return c < (b ? 7 : 3);
  endfunction

  task automatic check_wave(input string nm, input int len,
                            input logic [23:0] p0, input logic [23:0] p1,
                            input int nfr);
    int bad, first;
    logic el, ef;
    bad = 0; first = -1;
    for (int i = 0; i < len; i++) begin
      el = (i / 500 < nfr) ? pat(i % 500, p0, p1) : 1'b0;
      ef = (i > 0) && (i % 500 == 0) && (i / 500 <= nfr);
      if (cap_led[i] !== el || cap_fd[i] !== ef) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles (first at %0d), required 0",
               nm, bad, first);
    end
  endtask

  vec_t vt [17];

  initial begin
    logic [31:0] rd;
    logic err;
    int lows;

    vt[0]  = '{A_P0,   32'h0,        1'b0, 32'h0,        1'b0};
    vt[1]  = '{A_P1,   32'h0,        1'b0, 32'h0,        1'b0};
    vt[2]  = '{A_CTRL, 32'h0,        1'b0, 32'h0,        1'b0};
    vt[3]  = '{A_STAT, 32'h0,        1'b0, 32'h0,        1'b0};
    vt[4]  = '{A_P0,   32'hABCDEF12, 1'b1, 32'h0,        1'b0};
    vt[5]  = '{A_P0,   32'h0,        1'b0, 32'h00CDEF12, 1'b0};
    vt[6]  = '{32'h8,  32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
    vt[7]  = '{32'h8,  32'h0,        1'b0, 32'h0,        1'b1};
    vt[8]  = '{A_P0,   32'h0,        1'b0, 32'h00CDEF12, 1'b0};
    vt[9]  = '{A_CTRL, 32'h2,        1'b1, 32'h0,        1'b0};
    vt[10] = '{A_CTRL, 32'h0,        1'b0, 32'h2,        1'b0};
    vt[11] = '{A_CTRL, 32'h0,        1'b1, 32'h0,        1'b0};
    vt[12] = '{A_CTRL, 32'h0,        1'b0, 32'h0,        1'b0};
    vt[13] = '{A_STAT, 32'h0,        1'b0, 32'h0,        1'b0};
    vt[14] = '{32'h7F8, 32'h0,       1'b0, 32'h0,        1'b1};
    vt[15] = '{A_P1,   32'h12345678, 1'b1, 32'h0,        1'b0};
    vt[16] = '{A_P1,   32'h0,        1'b0, 32'h00345678, 1'b0};

    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_led", {31'h0, LED}, 32'h0);
    chk("rst_fd", {31'h0, FRAME_DONE}, 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_slverr", {31'h0, PSLVERR}, 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("pready", {31'h0, PREADY}, 32'h1);

    for (int i = 0; i < 17; i++) begin
      apb(vt[i].addr, vt[i].wdata, vt[i].wr, rd, err);
      chk($sformatf("vec%0d_err", i), {31'h0, err},
          {31'h0, vt[i].exp_err});
      if (!vt[i].wr)
        chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
    end

    // single frame
    wr32(A_P0, 32'h00FF0000);
    wr32(A_P1, 32'h00000001);
    wr32(A_CTRL, 32'h1);
    capture(540);
    check_wave("single_frame", 540, 24'hFF0000, 24'h000001, 1);
    rd_chk("done_after_frame", A_STAT, 32'h2);
    wr32(A_STAT, 32'h2);
    rd_chk("done_cleared", A_STAT, 32'h0);

    // START while busy at cycle ~100
    wr32(A_CTRL, 32'h1);
    fork
      capture(560);
      begin
        repeat (96) @(posedge PCLK);
        wr32(A_CTRL, 32'h1);
      end
    join
    check_wave("start_while_busy", 560, 24'hFF0000, 24'h000001, 1);
    rd_chk("idle_after_busy_start", A_STAT, 32'h2);

    // AUTO refresh, then clear AUTO during the third frame
    wr32(A_CTRL, 32'h3);
    fork
      capture(1600);
      begin
        repeat (1200) @(posedge PCLK);
        wr32(A_CTRL, 32'h0);
      end
    join
    check_wave("auto_refresh", 1600, 24'hFF0000, 24'h000001, 3);
    rd_chk("auto_cleared_idle", A_STAT, 32'h2);

    // pixel 1 rewritten while pixel 0 is shifting
    wr32(A_CTRL, 32'h1);
    fork
      capture(520);
      begin
        repeat (50) @(posedge PCLK);
        wr32(A_P1, 32'h00800000);
      end
    join
    check_wave("update_during_p0", 520, 24'hFF0000, 24'h800000, 1);
    chk("p1_first_bit_high", {31'h0, cap_led[247]}, 32'h1);

    // pixel 1 rewritten while pixel 1 is shifting
    wr32(A_P1, 32'h00000001);
    wr32(A_CTRL, 32'h1);
    fork
      capture(520);
      begin
        repeat (300) @(posedge PCLK);
        wr32(A_P1, 32'h00800000);
      end
    join
    check_wave("update_during_p1", 520, 24'hFF0000, 24'h000001, 1);
    wr32(A_CTRL, 32'h1);
    capture(520);
    check_wave("update_next_frame", 520, 24'hFF0000, 24'h800000, 1);

    // reset asserted during a high phase
    wr32(A_CTRL, 32'h1);
    repeat (3) @(posedge PCLK);
    #1;
    chk("led_high_pre_rst", {31'h0, LED}, 32'h1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("led_async_rst", {31'h0, LED}, 32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge PCLK);
      #1;
      if (LED === 1'b0 && FRAME_DONE === 1'b0) lows++;
    end
    chk("no_resume", lows, 40);
    rd_chk("rst_status", A_STAT, 32'h0);
    rd_chk("rst_pixel0", A_P0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
